// File: rtl/result_deskew_pkg.sv
// Shared types for the result deskew block: row-counter FSM states and
// the width helper used for the row index port.
package result_deskew_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } deskew_state_e;

    // A single-row tile still needs a 1-bit index port.
    function automatic int row_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/result_deskew_delay_line.sv
// Fixed-depth shift register with enable; q is the last registered stage,
// so a sample taken at edge t appears on q after edge t+DEPTH-1.
module delay_line #(
    parameter int DEPTH = 1,
    parameter int BITS  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);

    logic [BITS-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else if (en) begin
            stage_q[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/result_deskew.sv
// Realigns a skewed systolic result row (lane i arriving i cycles late)
// into one aligned row, and numbers the rows of each DIM-row tile.
module result_deskew
    import result_deskew_pkg::*;
#(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    vin,
    input  logic [DIM*BITS_C-1:0]   Cin,
    output logic [DIM*BITS_C-1:0]   Cout,
    output logic                    vout,
    output logic [row_w(DIM)-1:0]   row_idx,
    output logic                    done
);

    localparam int            RW   = row_w(DIM);
    localparam logic [RW-1:0] LAST = RW'(DIM - 1);

    logic          vld_q;
    logic [RW-1:0] row_q;
    deskew_state_e state_q;

    // Lane i arrives i cycles after lane 0, so it needs DIM-i stages to line up.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        delay_line #(
            .DEPTH (DIM - gi),
            .BITS  (BITS_C)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (Cin[gi*BITS_C +: BITS_C]),
            .q   (Cout[gi*BITS_C +: BITS_C])
        );
    end

    delay_line #(
        .DEPTH (DIM),
        .BITS  (1)
    ) u_valid (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (vin),
        .q   (vld_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
        end else if (en && vld_q) begin
            case (state_q)
                IDLE: begin
                    if (DIM > 1) begin
                        row_q   <= RW'(1);
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (row_q == LAST) begin
                        row_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        row_q <= row_q + RW'(1);
                    end
                end
            endcase
        end
    end

    // A frozen pipeline holds its last row, so qualify with en to keep vout/done low.
    assign vout    = vld_q & en;
    assign done    = vout & (row_q == LAST);
    assign row_idx = row_q;

endmodule

// File: tb/tb_result_deskew.sv
// Bench for result_deskew: a DIM=4 and a DIM=8 instance, checked every cycle
// against a history-based alignment model plus hand-computed expectations.
module tb_result_deskew;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_a [2];
    logic           en_a  [2];
    logic           vin_a [2];
    logic [W-1:0]   cin_a [2][8];

    logic [4*W-1:0] cin4, cout4;
    logic [8*W-1:0] cin8, cout8;
    logic           vout4, done4, vout8, done8;
    logic [1:0]     row4;
    logic [2:0]     row8;

    for (genvar gi = 0; gi < 8; gi++) begin : g_pack
        if (gi < 4) begin : g_p4
            assign cin4[gi*W +: W] = cin_a[0][gi];
        end
        assign cin8[gi*W +: W] = cin_a[1][gi];
    end

    result_deskew #(.BITS_C(W), .DIM(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst_a[0]),
        .en      (en_a[0]),
        .vin     (vin_a[0]),
        .Cin     (cin4),
        .Cout    (cout4),
        .vout    (vout4),
        .row_idx (row4),
        .done    (done4)
    );

    result_deskew #(.BITS_C(W), .DIM(8)) u_dut8 (
        .clk     (clk),
        .rst     (rst_a[1]),
        .en      (en_a[1]),
        .vin     (vin_a[1]),
        .Cin     (cin8),
        .Cout    (cout8),
        .vout    (vout8),
        .row_idx (row8),
        .done    (done8)
    );

    // Model state: everything accepted on enabled cycles since the last reset.
    logic         vin_h [2][1024];
    logic [W-1:0] cin_h [2][1024][8];
    int           n_en  [2];
    int           emit  [2];
    bit           model_ok [2];

    int checks = 0;
    int errors = 0;
    int cur_w  = 0;

    typedef struct {
        int           c;
        int           w;
        logic         v;
        logic         d;
        int           row;
        int           mode;
        logic [W-1:0] a;
    } lit_t;
    lit_t lits [$];

    function automatic int dim_of(input int c);
        return (c == 0) ? 4 : 8;
    endfunction

    task automatic chk(input string name, input int c, input int sub,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d[%0d] w=%0d got %0h expected %0h",
                     name, c, sub, cur_w, act, exp);
        end
    endtask

    task automatic get_out(input int c, output logic [8*W-1:0] co,
                           output logic av, output logic ad, output int ar);
        co = (c == 0) ? {64'b0, cout4} : cout8;
        av = (c == 0) ? vout4 : vout8;
        ad = (c == 0) ? done4 : done8;
        ar = (c == 0) ? int'(row4) : int'(row8);
    endtask

    // Row started at enabled cycle t emerges at t+DIM; lane i of it was fed at t+i.
    task automatic check_model(input int c);
        int           d_n = dim_of(c);
        int           n   = n_en[c];
        int           r   = emit[c] % dim_of(c);
        int           idx;
        logic         ev;
        logic [W-1:0] e;
        logic [8*W-1:0] co;
        logic         av, ad;
        int           ar;
        get_out(c, co, av, ad, ar);
        ev = 1'b0;
        if (n >= d_n) ev = en_a[c] & vin_h[c][n-d_n];
        chk("vout", c, 0, 32'(av), 32'(ev));
        chk("done", c, 0, 32'(ad), 32'(ev && (r == d_n - 1)));
        if (ev) chk("row_idx", c, 0, 32'(ar), 32'(r));
        for (int i = 0; i < d_n; i++) begin
            idx = n - d_n + i;
            e   = '0;
            if (idx >= 0) e = cin_h[c][idx][i];
            chk("lane", c, i, 32'(co[i*W +: W]), 32'(e));
        end
    endtask

    task automatic check_lits(input int c, input int w);
        logic [8*W-1:0] co;
        logic           av, ad;
        int             ar;
        logic [W-1:0]   e;
        get_out(c, co, av, ad, ar);
        foreach (lits[j]) begin
            if (lits[j].c == c && lits[j].w == w) begin
                chk("lit_vout", c, w, 32'(av), 32'(lits[j].v));
                chk("lit_done", c, w, 32'(ad), 32'(lits[j].d));
                if (lits[j].row >= 0) chk("lit_row", c, w, 32'(ar), 32'(lits[j].row));
                if (lits[j].mode != 0) begin
                    for (int i = 0; i < dim_of(c); i++) begin
                        e = (lits[j].mode == 1) ? W'(lits[j].a + W'(i)) : lits[j].a;
                        chk("lit_lane", c, i, 32'(co[i*W +: W]), 32'(e));
                    end
                end
            end
        end
    endtask

    task automatic update_model();
        int d_n;
        int n;
        for (int c = 0; c < 2; c++) begin
            d_n = dim_of(c);
            n   = n_en[c];
            if (rst_a[c]) begin
                n_en[c]     = 0;
                emit[c]     = 0;
                model_ok[c] = 1'b1;
            end else if (en_a[c] && model_ok[c] && n < 1024) begin
                if (n >= d_n && vin_h[c][n-d_n]) emit[c]++;
                vin_h[c][n] = vin_a[c];
                for (int i = 0; i < 8; i++) cin_h[c][n][i] = cin_a[c][i];
                n_en[c] = n + 1;
            end
        end
    endtask

    task automatic tick(input int w);
        cur_w = w;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            if (model_ok[c]) begin
                check_model(c);
                check_lits(c, w);
            end
        end
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic lit(input int c, input int w, input logic v, input logic d,
                       input int row, input int mode, input logic [W-1:0] a);
        lit_t t;
        t.c = c; t.w = w; t.v = v; t.d = d; t.row = row; t.mode = mode; t.a = a;
        lits.push_back(t);
    endtask

    function automatic logic [W-1:0] val(input int kind, input int r, input int i);
        case (kind)
            0:       return W'(10 + i);
            1:       return W'(16 * r + i);
            2:       return W'(100 + i);
            default: return (r % 2 == 0) ? 16'hFFFF : 16'h8000;
        endcase
    endfunction

    // Feeds nrows back-to-back skewed rows; filler data on lanes with no row.
    task automatic run(input int c, input int nrows, input int kind, input int ncyc,
                       input int stall_at, input int stall_len, input int rst_at);
        int k = 0;
        int r;
        $display("run cfg%0d dim=%0d rows=%0d kind=%0d cycles=%0d stall=%0d+%0d rst_at=%0d",
                 c, dim_of(c), nrows, kind, ncyc, stall_at, stall_len, rst_at);
        for (int w = 0; w < ncyc; w++) begin
            en_a[c]  = !(w >= stall_at && w < stall_at + stall_len);
            rst_a[c] = (w == rst_at);
            vin_a[c] = (k < nrows);
            for (int i = 0; i < 8; i++) begin
                r = k - i;
                cin_a[c][i] = (r >= 0 && r < nrows) ? val(kind, r, i) : W'(23040 + k * 8 + i);
            end
            tick(w);
            if (en_a[c] && !rst_a[c]) k++;
        end
        lits.delete();
        en_a[c]  = 1'b1;
        rst_a[c] = 1'b0;
        vin_a[c] = 1'b0;
    endtask

    // vin/en held high during reset: reset must win and the row must be dropped.
    task automatic do_reset(input int c);
        rst_a[c] = 1'b1;
        en_a[c]  = 1'b1;
        vin_a[c] = 1'b1;
        tick(-1);
        rst_a[c] = 1'b0;
        vin_a[c] = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            rst_a[c] = 1'b1;
            en_a[c]  = 1'b0;
            vin_a[c] = 1'b0;
            n_en[c]  = 0;
            emit[c]  = 0;
            model_ok[c] = 1'b0;
            for (int i = 0; i < 8; i++) cin_a[c][i] = '0;
        end
        tick(-1);
        for (int c = 0; c < 2; c++) begin
            rst_a[c] = 1'b0;
            en_a[c]  = 1'b1;
        end

        // Single row 10+i: aligned at cycle 4, reset state visible at cycle 0.
        do_reset(0);
        lit(0, 0, 1'b0, 1'b0, 0, 2, 16'd0);
        lit(0, 4, 1'b1, 1'b0, 0, 1, 16'd10);
        run(0, 1, 0, 8, -1, 0, -1);

        // Four back-to-back rows 16r+i: rows 0..3 on cycles 4..7, done at 7.
        do_reset(0);
        lit(0, 4, 1'b1, 1'b0, 0, 1, 16'd0);
        lit(0, 5, 1'b1, 1'b0, 1, 1, 16'd16);
        lit(0, 7, 1'b1, 1'b1, 3, 1, 16'd48);
        lit(0, 8, 1'b0, 1'b0, 0, 0, 16'd0);
        run(0, 4, 1, 10, -1, 0, -1);

        // Three-cycle stall mid-row: output slides from cycle 4 to 7.
        do_reset(0);
        lit(0, 3, 1'b0, 1'b0, -1, 0, 16'd0);
        lit(0, 6, 1'b0, 1'b0, -1, 0, 16'd0);
        lit(0, 7, 1'b1, 1'b0, 0, 1, 16'd100);
        run(0, 1, 2, 10, 2, 3, -1);

        // Reset after two rows: they never emerge, next tile starts at row 0.
        do_reset(0);
        run(0, 2, 1, 3, -1, 0, 2);
        lit(0, 1, 1'b0, 1'b0, 0, 0, 16'd0);
        lit(0, 2, 1'b0, 1'b0, 0, 0, 16'd0);
        lit(0, 4, 1'b1, 1'b0, 0, 1, 16'd0);
        lit(0, 5, 1'b1, 1'b0, 1, 1, 16'd16);
        run(0, 4, 1, 9, -1, 0, -1);

        // DIM=8 extreme negatives, full tile with done at latency 8 + 7.
        do_reset(1);
        lit(1, 0, 1'b0, 1'b0, 0, 2, 16'd0);
        lit(1, 8, 1'b1, 1'b0, 0, 2, 16'hFFFF);
        lit(1, 9, 1'b1, 1'b0, 1, 2, 16'h8000);
        lit(1, 15, 1'b1, 1'b1, 7, 2, 16'h8000);
        lit(1, 16, 1'b0, 1'b0, 0, 0, 16'd0);
        run(1, 8, 3, 18, -1, 0, -1);

        // Tile 2 row 0 directly after tile 1 row 3.
        do_reset(0);
        lit(0, 7, 1'b1, 1'b1, 3, 1, 16'd48);
        lit(0, 8, 1'b1, 1'b0, 0, 1, 16'd64);
        lit(0, 11, 1'b1, 1'b1, 3, 1, 16'd112);
        run(0, 8, 1, 14, -1, 0, -1);

        // Gap inside a tile: row index holds at 2, then rows 2 and 3 finish it.
        do_reset(0);
        run(0, 2, 1, 6, -1, 0, -1);
        lit(0, 0, 1'b0, 1'b0, 2, 0, 16'd0);
        lit(0, 4, 1'b1, 1'b0, 2, 1, 16'd0);
        lit(0, 5, 1'b1, 1'b1, 3, 1, 16'd16);
        lit(0, 6, 1'b0, 1'b0, 0, 0, 16'd0);
        run(0, 2, 1, 8, -1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
